mod12_count_tracker: RTL and testbench
======================================

# mod12_count_tracker

Downstream monitor and formatter for the mod-12 up/down counter. Samples the counter's 4-bit count and direction every clock, converts the count to two BCD digits, and pulses on every wrap (11→0 up, 0→11 down). Keeps a modulo-2^EPOCH_W epoch count of net wraps and raises sticky errors when the count leaves 0..11 or moves by anything other than the step implied by the previous direction. Feeds the display and status logic.

## Interface
- EPOCH_W, 8, width of the epoch (net wrap) counter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- q_in  in  4  count from the mod-12 counter
- mod_in  in  1  counter direction input (1 = up, 0 = down), same cycle as q_in
- err_clr  in  1  clears sticky errors and resynchronises
- bcd_tens  out  4  tens digit of last sampled count (0 or 1)
- bcd_ones  out  4  ones digit of last sampled count (0..9)
- wrap_up  out  1  one-cycle pulse: up wrap 11→0 detected
- wrap_dn  out  1  one-cycle pulse: down wrap 0→11 detected
- epoch  out  EPOCH_W  net wraps since reset/resync, modulo 2^EPOCH_W
- err_range  out  1  sticky: q_in > 11 sampled
- err_step  out  1  sticky: illegal step between consecutive samples
- locked  out  1  high in TRACK state

## Operation
- Registers: p (previous q_in, 4 b), d (previous mod_in), state, all outputs.
- Every edge (not in reset): p←q_in, d←mod_in; bcd digits ← conversion of q_in (10/11 → tens 1, ones 0/1; q_in>11 → both 4'hF).
- Expected next value: d=1 → (p==11 ? 0 : p+1); d=0 → (p==0 ? 11 : p−1). Arithmetic is 4-bit, wrap handled explicitly, never by overflow.
- States:
  - EMPTY: no valid p. Captures only, no step check, no pulses. q_in ≤ 11 → TRACK; q_in > 11 → FAULT, err_range←1.
  - TRACK: q_in > 11 → FAULT, err_range←1. Else q_in ≠ expected → FAULT, err_step←1. Else stay. wrap_up when d=1, p=11, q_in=0; epoch+1. wrap_dn when d=0, p=0, q_in=11; epoch−1. Epoch wraps modulo 2^EPOCH_W (255+1→0, 0−1→255).
  - FAULT: captures p/d, updates bcd, no pulses, epoch frozen, flags held. err_clr → EMPTY.
- err_clr: clears err_range, err_step, epoch→0, state→EMPTY, in any state. err_clr wins over an error detected the same edge. The sample is still captured into p/d.
- Simultaneous range and step violation: only err_range is set.
- rst beats err_clr and all other inputs.

## Timing
- Reset values: bcd_tens=0, bcd_ones=0, wrap_up=0, wrap_dn=0, epoch=0, err_range=0, err_step=0, locked=0, p=0, d=0, state=EMPTY.
- Latency 1: sample at edge k produces outputs visible after edge k.
- wrap_up/wrap_dn are exactly one cycle wide and never both high.
- The first edge after rst/err_clr is never checked (EMPTY). locked rises after that edge.
- Reset mid-operation: next cycle matches reset values. The first post-reset sample is treated as unchecked.

## Structure
- Package mod12_pkg: MOD12_MAX = 4'd11, BCD_INVALID = 4'hF, state enum {EMPTY, TRACK, FAULT}, function next_expected(p, d).
- Sub-module mod12_to_bcd: combinational 4-bit → tens/ones converter with the invalid mapping. Reused by the display path.
- Top holds the FSM, p/d registers, wrap detect, epoch and sticky flags.

## Test plan
- Reset, then q_in 0,1,…,11,0 with mod_in=1 → locked after first edge, bcd follows (11 → tens 1, ones 1), wrap_up single pulse after the 0 sample, epoch=1, no errors.
- From epoch=0, q_in 0,11,10 with mod_in=0 → wrap_dn pulse after the 11 sample, epoch=255, no errors.
- In TRACK with p=5, d=1: q_in=7 → err_step=1, locked=0, epoch frozen. Subsequent legal steps produce no pulses.
- q_in=13 in TRACK → err_range=1, err_step=0, bcd_tens=bcd_ones=4'hF. Then err_clr with q_in=3 → flags 0, epoch 0, EMPTY, locked after the following edge.
- Direction change: q_in 4,5,4 with mod_in 1 then 0 → no errors. Same sequence with mod_in held 1 → err_step.
- rst asserted together with err_clr while in FAULT with epoch=9 → all reset values next cycle.

Source files
------------

// File: rtl/mod12_pkg.sv
// Shared constants, FSM state type and step prediction for the mod-12 count tracker.
package mod12_pkg;

  localparam logic [3:0] MOD12_MAX   = 4'd11;
  localparam logic [3:0] BCD_INVALID = 4'hF;

  typedef enum logic [1:0] {
    StEmpty,
    StTrack,
    StFault
  } state_e;

  // Value the counter must present next, given the previous count and direction.
  function automatic logic [3:0] next_expected(input logic [3:0] p, input logic d);
    logic [3:0] nxt;
    if (d) begin
      nxt = (p == MOD12_MAX) ? 4'd0 : p + 4'd1;
    end else begin
      nxt = (p == 4'd0) ? MOD12_MAX : p - 4'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mod12_to_bcd.sv
// Combinational 4-bit count to two-digit BCD; codes above 11 map to BCD_INVALID on both digits.
module mod12_to_bcd
  import mod12_pkg::*;
(
  input  logic [3:0] bin_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o
);

  always_comb begin
    tens_o = 4'd0;
    ones_o = bin_i;
    if (bin_i > MOD12_MAX) begin
      tens_o = BCD_INVALID;
      ones_o = BCD_INVALID;
    end else if (bin_i >= 4'd10) begin
      tens_o = 4'd1;
      ones_o = bin_i - 4'd10;
    end
  end

endmodule

// File: rtl/mod12_count_tracker.sv
// Monitors a mod-12 up/down counter: BCD display, wrap pulses, net-wrap epoch and sticky
// range/step error flags.
module mod12_count_tracker
  import mod12_pkg::*;
#(
  parameter int unsigned EPOCH_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         q_in,
  input  logic               mod_in,
  input  logic               err_clr,
  output logic [3:0]         bcd_tens,
  output logic [3:0]         bcd_ones,
  output logic               wrap_up,
  output logic               wrap_dn,
  output logic [EPOCH_W-1:0] epoch,
  output logic               err_range,
  output logic               err_step,
  output logic               locked
);

  state_e               state_q, state_d;
  logic [3:0]           p_q, p_d;
  logic                 d_q, d_d;
  logic [3:0]           tens_q, tens_d, ones_q, ones_d;
  logic                 wrap_up_q, wrap_up_d, wrap_dn_q, wrap_dn_d;
  logic [EPOCH_W-1:0]   epoch_q, epoch_d;
  logic                 err_range_q, err_range_d, err_step_q, err_step_d;
  logic                 locked_q, locked_d;

  logic [3:0] conv_tens, conv_ones, expected;
  logic       in_range;

  mod12_to_bcd u_bcd (
    .bin_i  (q_in),
    .tens_o (conv_tens),
    .ones_o (conv_ones)
  );

  assign expected = next_expected(p_q, d_q);
  assign in_range = (q_in <= MOD12_MAX);

  always_comb begin
    state_d     = state_q;
    p_d         = q_in;
    d_d         = mod_in;
    tens_d      = conv_tens;
    ones_d      = conv_ones;
    wrap_up_d   = 1'b0;
    wrap_dn_d   = 1'b0;
    epoch_d     = epoch_q;
    err_range_d = err_range_q;
    err_step_d  = err_step_q;

    // err_clr overrides any error detected on the same edge; the sample is still captured.
    if (err_clr) begin
      state_d     = StEmpty;
      epoch_d     = '0;
      err_range_d = 1'b0;
      err_step_d  = 1'b0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (!in_range) begin
            state_d     = StFault;
            err_range_d = 1'b1;
          end else begin
            state_d = StTrack;
          end
        end
        StTrack: begin
          if (!in_range) begin
            state_d     = StFault;
            err_range_d = 1'b1;
          end else if (q_in != expected) begin
            state_d    = StFault;
            err_step_d = 1'b1;
          end else if (d_q && (p_q == MOD12_MAX) && (q_in == 4'd0)) begin
            wrap_up_d = 1'b1;
            epoch_d   = epoch_q + EPOCH_W'(1);
          end else if (!d_q && (p_q == 4'd0) && (q_in == MOD12_MAX)) begin
            wrap_dn_d = 1'b1;
            epoch_d   = epoch_q - EPOCH_W'(1);
          end
        end
        StFault: ;
        default: state_d = StEmpty;
      endcase
    end

    locked_d = (state_d == StTrack);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      p_q         <= 4'd0;
      d_q         <= 1'b0;
      tens_q      <= 4'd0;
      ones_q      <= 4'd0;
      wrap_up_q   <= 1'b0;
      wrap_dn_q   <= 1'b0;
      epoch_q     <= '0;
      err_range_q <= 1'b0;
      err_step_q  <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      d_q         <= d_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      wrap_up_q   <= wrap_up_d;
      wrap_dn_q   <= wrap_dn_d;
      epoch_q     <= epoch_d;
      err_range_q <= err_range_d;
      err_step_q  <= err_step_d;
      locked_q    <= locked_d;
    end
  end

  assign bcd_tens  = tens_q;
  assign bcd_ones  = ones_q;
  assign wrap_up   = wrap_up_q;
  assign wrap_dn   = wrap_dn_q;
  assign epoch     = epoch_q;
  assign err_range = err_range_q;
  assign err_step  = err_step_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_mod12_count_tracker.sv
// Scoreboard bench for mod12_count_tracker: directed scenarios plus random traffic against a
// behavioural model of the counter-following rules.
module tb_mod12_count_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] q_in = 4'd0;
  logic       mod_in = 1'b0;
  logic       err_clr = 1'b0;
  logic [3:0] bcd_tens, bcd_ones;
  logic       wrap_up, wrap_dn;
  logic [7:0] epoch;
  logic       err_range, err_step, locked;

  mod12_count_tracker #(.EPOCH_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .q_in      (q_in),
    .mod_in    (mod_in),
    .err_clr   (err_clr),
    .bcd_tens  (bcd_tens),
    .bcd_ones  (bcd_ones),
    .wrap_up   (wrap_up),
    .wrap_dn   (wrap_dn),
    .epoch     (epoch),
    .err_range (err_range),
    .err_step  (err_step),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tens, ones, wu, wd, ep, er, es, lk;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Model state, expressed in terms of the counter's rules rather than the RTL encoding.
  bit m_tracking = 0;
  bit m_faulted  = 0;
  int m_prev     = 0;
  int m_dir      = 0;
  int m_ep       = 0;
  int m_er       = 0;
  int m_es       = 0;

  int last_q = 0;
  int last_m = 1;

  function automatic exp_t model_step(input bit r, input bit c, input int q, input int m);
    exp_t e;
    e.wu = 0;
    e.wd = 0;
    if (r) begin
      m_tracking = 0; m_faulted = 0; m_prev = 0; m_dir = 0; m_ep = 0; m_er = 0; m_es = 0;
      e.tens = 0; e.ones = 0; e.ep = 0; e.er = 0; e.es = 0; e.lk = 0;
      return e;
    end
    if (c) begin
      m_er = 0; m_es = 0; m_ep = 0; m_tracking = 0; m_faulted = 0;
    end else if (m_faulted) begin
      // frozen until cleared
    end else if (!m_tracking) begin
      if (q > 11) begin m_faulted = 1; m_er = 1; end
      else m_tracking = 1;
    end else begin
      if (q > 11) begin
        m_faulted = 1; m_tracking = 0; m_er = 1;
      end else if (q != (m_prev + (m_dir ? 1 : 11)) % 12) begin
        m_faulted = 1; m_tracking = 0; m_es = 1;
      end else if (m_dir == 1 && m_prev == 11 && q == 0) begin
        e.wu = 1; m_ep = (m_ep + 1) % 256;
      end else if (m_dir == 0 && m_prev == 0 && q == 11) begin
        e.wd = 1; m_ep = (m_ep + 255) % 256;
      end
    end
    m_prev = q;
    m_dir  = m;
    if (q > 11) begin e.tens = 15; e.ones = 15; end
    else begin e.tens = q / 10; e.ones = q % 10; end
    e.ep = m_ep; e.er = m_er; e.es = m_es;
    e.lk = (m_tracking && !m_faulted) ? 1 : 0;
    return e;
  endfunction

  task automatic cyc(input bit r, input bit c, input int q, input int m);
    exp_t e;
    @(negedge clk);
    rst = r; err_clr = c; q_in = q[3:0]; mod_in = m[0];
    e = model_step(r, c, q, m);
    exp_q.push_back(e);
    last_q = q; last_m = m;
  endtask

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, want);
    end
  endtask

  // Monitor: every DUT output cycle is matched against the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("bcd_tens",  int'(bcd_tens),  e.tens);
        chk("bcd_ones",  int'(bcd_ones),  e.ones);
        chk("wrap_up",   int'(wrap_up),   e.wu);
        chk("wrap_dn",   int'(wrap_dn),   e.wd);
        chk("epoch",     int'(epoch),     e.ep);
        chk("err_range", int'(err_range), e.er);
        chk("err_step",  int'(err_step),  e.es);
        chk("locked",    int'(locked),    e.lk);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int r, q, m;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);

    // Count up through a full wrap.
    for (int i = 0; i <= 11; i++) cyc(0, 0, i, 1);
    cyc(0, 0, 0, 1);

    // Down wrap from epoch 0.
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 11, 0);
    cyc(0, 0, 10, 0);

    // Illegal step 5 -> 7, then legal-looking steps stay faulted.
    cyc(0, 1, 4, 1);
    cyc(0, 0, 5, 1);
    cyc(0, 0, 7, 1);
    cyc(0, 0, 8, 1);
    cyc(0, 0, 9, 1);
    cyc(0, 0, 10, 1);
    cyc(0, 0, 11, 1);
    cyc(0, 0, 0, 1);

    // Out-of-range sample, then clear with q=3.
    cyc(0, 1, 2, 1);
    cyc(0, 0, 3, 1);
    cyc(0, 0, 13, 1);
    cyc(0, 1, 3, 1);
    cyc(0, 0, 4, 1);

    // Direction change is legal; holding direction is not.
    cyc(0, 1, 4, 1);
    cyc(0, 0, 5, 0);
    cyc(0, 0, 4, 0);
    cyc(0, 0, 3, 0);
    cyc(0, 1, 4, 1);
    cyc(0, 0, 5, 1);
    cyc(0, 0, 4, 1);

    // Build epoch 9, fault, then rst together with err_clr.
    cyc(0, 1, 0, 1);
    for (int w = 0; w < 9; w++) for (int i = 1; i <= 12; i++) cyc(0, 0, i % 12, 1);
    cyc(0, 0, 14, 1);
    cyc(1, 1, 5, 1);
    cyc(0, 0, 5, 1);
    cyc(0, 0, 6, 1);

    // Epoch wrap 255 -> 0 via down then up wraps.
    cyc(0, 1, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 11, 1);
    cyc(0, 0, 0, 1);

    // Random traffic, mostly legal.
    for (int n = 0; n < 1500; n++) begin
      r = int'($urandom_range(0, 99));
      m = ($urandom_range(0, 99) < 15) ? 1 - last_m : last_m;
      if (r < 1) cyc(1, 0, int'($urandom_range(0, 15)), m);
      else if (r < 4) cyc(0, 1, int'($urandom_range(0, 15)), m);
      else if (r < 6) cyc(0, 0, int'($urandom_range(12, 15)), m);
      else if (r < 10) cyc(0, 0, int'($urandom_range(0, 11)), m);
      else begin
        q = (last_q > 11) ? 0 : (last_q + (last_m ? 1 : 11)) % 12;
        cyc(0, 0, q, m);
      end
    end

    @(negedge clk);
    @(negedge clk);
    chk("pending", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
